shift_cmd_fifo: RTL and testbench



---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_cmd_buf.sv | 59 +++++
 rtl/shift_cmd_fifo.sv | 81 ++++++++
 tb/tb_shift_cmd_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and widths for the shift command front end.
//   DATA_W      : width of the data word handed to the barrel shifter
//   SEL_W       : width of the shift amount
//   shift_cmd_t : one queued command, {sel, data}
package shift_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 2;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_buf.sv
// Command storage for shift_cmd_fifo: DEPTH x shift_cmd_t circular buffer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push      : write wr_cmd at the write pointer (caller guarantees !full)
//   wr_cmd    : command to store
//   pop       : drop the head entry (caller guarantees !empty)
//   head      : entry at the read pointer (undefined content when empty)
//   count     : occupancy, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
module shift_cmd_buf
    import shift_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  shift_cmd_t    wr_cmd,
    input  logic          pop,
    output shift_cmd_t    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    shift_cmd_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Occupancy is kept alongside the pointers so equal pointers are never
    // ambiguous between full and empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= wr_cmd;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/shift_cmd_fifo.sv
// Buffered command front end for an external combinational 4-bit barrel
// shifter. Commands queue in shift_cmd_buf; the head drives the shifter and
// the shifter result is registered into a valid/ready output stage.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : command handshake, in_data + in_sel
//   sh_din/sh_sel       : head command to the shifter (zero when empty)
//   sh_dout             : shifter result
//   out_valid/out_ready : result handshake, out_data + out_sel
//   count               : FIFO occupancy, 0..DEPTH (excludes output register)
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [DATA_W-1:0] sh_din,
    output logic [SEL_W-1:0]  sh_sel,
    input  logic [DATA_W-1:0] sh_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic [CW-1:0]     count
);

    shift_cmd_t head;
    shift_cmd_t wr_cmd;
    logic       full;
    logic       empty;
    logic       push;
    logic       load;

    // in_ready looks only at occupancy, so out_ready never reaches it
    // combinationally; a full FIFO refuses a push even if it pops that cycle.
    assign in_ready = !full;
    assign push     = in_valid && in_ready && !rst;
    assign wr_cmd   = {in_sel, in_data};

    // Output register is free when empty or being consumed this cycle.
    assign load = !empty && (!out_valid || out_ready);

    shift_cmd_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_cmd (wr_cmd),
        .pop    (load),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Stale storage must not leak to the shifter when nothing is queued.
    assign sh_din = empty ? '0 : head.data;
    assign sh_sel = empty ? '0 : head.sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sh_dout;
            out_sel   <= head.sel;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_cmd_fifo.sv
`timescale 1ns/1ps
module tb_shift_cmd_fifo;
    import shift_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_data;
    logic [1:0]    in_sel;
    logic [3:0]    sh_din;
    logic [1:0]    sh_sel;
    logic [3:0]    sh_dout;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_data;
    logic [1:0]    out_sel;
    logic [CW-1:0] count;

    shift_cmd_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .sh_din    (sh_din),
        .sh_sel    (sh_sel),
        .sh_dout   (sh_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .count     (count)
    );

    // Barrel shifter sitting beside the block: logical left shift by sel.
    assign sh_dout = sh_din << sh_sel;

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         n_out     = 0;
    int         max_count = 0;
    bit         rand_rdy  = 1'b0;
    shift_cmd_t sb[$];

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: transfers are decided at the next rising edge, so both
    // handshakes are observed on the falling edge before it.
    always @(negedge clk) begin
        shift_cmd_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (int'(count) > max_count) max_count = int'(count);
            if (out_valid && out_ready) begin
                n_out++;
                check_eq("sb_nonempty", 8'(sb.size() != 0), 8'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("out_data", 8'(out_data), 8'(e.data));
                    check_eq("out_sel", 8'(out_sel), 8'(e.sel));
                end
            end
            if (in_valid && in_ready) begin
                e.sel  = in_sel;
                e.data = 4'(in_data << in_sel);
                sb.push_back(e);
            end
        end
    end

    task automatic push_cmd(input logic [3:0] d, input logic [1:0] s);
        int   waits = 0;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        do begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            acc = in_ready;
            @(posedge clk); #1;
            waits++;
        end while (!acc && waits < 100);
        if (!acc) check_eq("push_accept", 8'(acc), 8'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((count != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain_done", 8'(count != 0 || out_valid), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", 8'(count), 8'd0);
        check_eq("rst_out_valid", 8'(out_valid), 8'd0);
        check_eq("rst_out_data", 8'(out_data), 8'd0);
        check_eq("rst_out_sel", 8'(out_sel), 8'd0);
        check_eq("rst_in_ready", 8'(in_ready), 8'd1);
        check_eq("rst_sh_din", 8'(sh_din), 8'd0);
        check_eq("rst_sh_sel", 8'(sh_sel), 8'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single command, 2-cycle latency, no bypass
        out_ready = 1'b1;
        push_cmd(4'b1001, 2'b01);
        check_eq("single_no_bypass", 8'(out_valid), 8'd0);
        check_eq("single_count", 8'(count), 8'd1);
        check_eq("single_sh_din", 8'(sh_din), 8'b1001);
        check_eq("single_sh_sel", 8'(sh_sel), 8'b01);
        @(posedge clk); #1;
        check_eq("single_valid", 8'(out_valid), 8'd1);
        check_eq("single_data", 8'(out_data), 8'b0010);
        check_eq("single_sel", 8'(out_sel), 8'b01);
        check_eq("single_count0", 8'(count), 8'd0);
        @(posedge clk); #1;
        check_eq("single_drop", 8'(out_valid), 8'd0);

        // Sweep of all shift amounts, back to back
        base = n_out;
        for (int i = 0; i < 4; i++) push_cmd(4'b1001, 2'(i));
        check_eq("sweep_valid", 8'(out_valid), 8'd1);
        check_eq("sweep_mid_data", 8'(out_data), 8'b0100);
        drain();
        check_eq("sweep_n_out", 8'(n_out - base), 8'd4);

        // Fill under stall, blocked push at full, then simultaneous push/pop
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(4'($urandom), 2'($urandom));
        check_eq("fill_in_ready", 8'(in_ready), 8'd0);
        check_eq("fill_count", 8'(count), 8'd4);
        check_eq("fill_out_valid", 8'(out_valid), 8'd1);
        in_valid = 1'b1;
        in_data  = 4'b0111;
        in_sel   = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_eq("full_hold_count", 8'(count), 8'd4);
            check_eq("full_hold_ready", 8'(in_ready), 8'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("full_pop_count", 8'(count), 8'd3);
        check_eq("full_pop_ready", 8'(in_ready), 8'd1);
        check_eq("full_pop_valid", 8'(out_valid), 8'd1);
        @(posedge clk); #1;
        check_eq("pushpop_count", 8'(count), 8'd3);
        in_valid = 1'b0;
        drain();
        check_eq("fill_ready_back", 8'(in_ready), 8'd1);
        check_eq("fill_sb_empty", 8'(sb.size()), 8'd0);

        // Wrap-around with random back-pressure
        base     = n_out;
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++) push_cmd(4'($urandom), 2'($urandom));
        rand_rdy = 1'b0;
        drain();
        check_eq("wrap_n_out", 8'(n_out - base), 8'd12);
        check_eq("wrap_sb_empty", 8'(sb.size()), 8'd0);
        check_eq("wrap_max_count_ok", 8'(max_count <= DEPTH), 8'd1);

        // Reset mid-stream with queued commands and a held result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(4'($urandom), 2'($urandom));
        check_eq("pre_rst_count", 8'(count), 8'd3);
        check_eq("pre_rst_valid", 8'(out_valid), 8'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_sel   = 2'b11;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("mid_rst_count", 8'(count), 8'd0);
        check_eq("mid_rst_valid", 8'(out_valid), 8'd0);
        check_eq("mid_rst_sh_din", 8'(sh_din), 8'd0);
        check_eq("mid_rst_in_ready", 8'(in_ready), 8'd1);
        out_ready = 1'b1;
        push_cmd(4'b0011, 2'b01);
        drain();
        check_eq("post_rst_sb_empty", 8'(sb.size()), 8'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
